// File: rtl/modbus_frame_tx_if.sv
// Response-frame handshake between the Modbus slave logic, the framer and the UART.
// The slave modport is the framer side; master is the slave-logic/UART side.
interface modbus_frame_tx_if #(
  parameter int MAX_BYTES = 8
);
  logic [8*MAX_BYTES-1:0] frame_data_in;
  logic [3:0]             frame_len_in;
  logic                   send_req;
  logic                   uart_busy_in;
  logic [7:0]             uart_data_out;
  logic                   uart_start_out;
  logic                   busy_out;
  logic                   tx_done;
  logic                   len_err;
  logic [15:0]            crc_out;

  modport slave (
    input  frame_data_in, frame_len_in, send_req, uart_busy_in,
    output uart_data_out, uart_start_out, busy_out, tx_done, len_err, crc_out
  );

  modport master (
    output frame_data_in, frame_len_in, send_req, uart_busy_in,
    input  uart_data_out, uart_start_out, busy_out, tx_done, len_err, crc_out
  );
endinterface

// File: rtl/modbus_frame_tx.sv
// Modbus RTU transmit framer: streams payload bytes to the UART, appends
// CRC-16/Modbus (low byte first) and enforces the t3.5 silence gap.
module modbus_frame_tx #(
  parameter int          MAX_BYTES  = 8,
  parameter logic [15:0] GAP_CYCLES = 16'd1750
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  modbus_frame_tx_if.slave   bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_CRC  = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_NEXT = 3'd5;
  localparam logic [2:0] ST_GAP  = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  localparam int         DW      = 8 * MAX_BYTES;
  localparam logic [4:0] MAX_LEN = 5'(MAX_BYTES);

  function automatic logic [15:0] crc_bit_step(input logic [15:0] crc);
    if (crc[0]) begin
      crc_bit_step = (crc >> 1) ^ 16'hA001;
    end else begin
      crc_bit_step = crc >> 1;
    end
  endfunction

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]    len_q, len_d;
  logic [4:0]    idx_q, idx_d;
  logic [2:0]    bit_q, bit_d;
  logic [15:0]   gap_q, gap_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    uart_data_q, uart_data_d;
  logic          uart_start_q, uart_start_d;
  logic          busy_q, busy_d;
  logic          tx_done_q, tx_done_d;
  logic          len_err_q, len_err_d;
  logic [15:0]   crc_out_q, crc_out_d;

  logic [7:0]    pay_byte_s;
  logic          is_crc_byte_s;
  logic          len_ok_s;

  // Select the payload byte addressed by the current index.
  always_comb begin
    pay_byte_s = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx_q == 5'(k)) begin
        pay_byte_s = data_q[DW-1-8*k -: 8];
      end else begin
        pay_byte_s = pay_byte_s;
      end
    end
  end

  assign is_crc_byte_s = (idx_q >= {1'b0, len_q});
  assign len_ok_s      = (bus.frame_len_in != 4'd0) && ({1'b0, bus.frame_len_in} <= MAX_LEN);

  // Next-state and datapath logic for the framing sequence.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    len_d        = len_q;
    idx_d        = idx_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    crc_d        = crc_q;
    uart_data_d  = uart_data_q;
    uart_start_d = 1'b0;
    len_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.send_req && len_ok_s) begin
          data_d  = bus.frame_data_in;
          len_d   = bus.frame_len_in;
          crc_d   = 16'hFFFF;
          idx_d   = 5'd0;
          state_d = ST_LOAD;
        end else if (bus.send_req) begin
          len_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!is_crc_byte_s) begin
          uart_data_d = pay_byte_s;
          crc_d       = {crc_q[15:8], crc_q[7:0] ^ pay_byte_s};
        end else if (idx_q == {1'b0, len_q}) begin
          uart_data_d = crc_q[7:0];
        end else begin
          uart_data_d = crc_q[15:8];
        end
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!bus.uart_busy_in) begin
          uart_start_d = 1'b1;
          bit_d        = 3'd0;
          state_d      = is_crc_byte_s ? ST_WAIT : ST_CRC;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_CRC: begin
        crc_d = crc_bit_step(crc_q);
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_CRC;
        end
      end
      ST_WAIT: begin
        // A CRC byte arrives here with its strobe still visible; busy only rises after it.
        if (!bus.uart_busy_in && !uart_start_q) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_NEXT: begin
        idx_d = idx_q + 5'd1;
        if (idx_q < ({1'b0, len_q} + 5'd1)) begin
          state_d = ST_LOAD;
        end else begin
          gap_d   = GAP_CYCLES;
          state_d = (GAP_CYCLES == 16'd0) ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q <= 16'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the upcoming state so they align with it.
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    tx_done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      crc_out_d = crc_q;
    end else begin
      crc_out_d = crc_out_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      len_q        <= 4'd0;
      idx_q        <= 5'd0;
      bit_q        <= 3'd0;
      gap_q        <= 16'd0;
      crc_q        <= 16'hFFFF;
      uart_data_q  <= 8'h00;
      uart_start_q <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      len_err_q    <= 1'b0;
      crc_out_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      crc_q        <= crc_d;
      uart_data_q  <= uart_data_d;
      uart_start_q <= uart_start_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
      len_err_q    <= len_err_d;
      crc_out_q    <= crc_out_d;
    end
  end

  assign bus.uart_data_out  = uart_data_q;
  assign bus.uart_start_out = uart_start_q;
  assign bus.busy_out       = busy_q;
  assign bus.tx_done        = tx_done_q;
  assign bus.len_err        = len_err_q;
  assign bus.crc_out        = crc_out_q;

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Directed bench for modbus_frame_tx with a 10-cycle-busy UART model.
module tb_modbus_frame_tx;

  localparam int          MAXB = 8;
  localparam logic [15:0] GAP  = 16'd40;
  localparam logic [63:0] F1   = 64'h0103_0000_0001_0000;
  localparam logic [63:0] F2   = 64'h0103_0000_000A_0000;
  localparam logic [63:0] F3   = 64'h0100_0000_0000_0000;
  localparam logic [7:0]  EXP1 [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
  localparam logic [7:0]  EXP2 [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
  localparam logic [7:0]  EXP3 [3] = '{8'h01, 8'h7E, 8'h80};

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  bit   hold_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int n_strobe = 0;
  int n_txdone = 0;
  int n_lenerr = 0;
  int stab_err = 0;
  int fall_edge = 0;
  int done_edge = 0;
  bit done_busy = 1'b0;
  bit in_byte = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] cap [128];

  modbus_frame_tx_if #(.MAX_BYTES(MAXB)) bus ();

  modbus_frame_tx #(.MAX_BYTES(MAXB), .GAP_CYCLES(GAP)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // UART model and output monitor, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      busy_cnt         <= 0;
      bus.uart_busy_in <= 1'b0;
      in_byte          <= 1'b0;
    end else begin
      if (bus.uart_start_out) busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      bus.uart_busy_in <= hold_busy || (busy_cnt != 0);
      if (bus.uart_busy_in && !(hold_busy || (busy_cnt != 0))) begin
        fall_edge <= cyc + 1;
        in_byte   <= 1'b0;
      end
    end
    if (bus.uart_start_out) begin
      cap[n_strobe % 128] <= bus.uart_data_out;
      n_strobe  <= n_strobe + 1;
      last_data <= bus.uart_data_out;
      in_byte   <= 1'b1;
    end else if (in_byte && (bus.uart_data_out !== last_data)) begin
      stab_err <= stab_err + 1;
    end
    if (bus.tx_done) begin
      n_txdone  <= n_txdone + 1;
      done_edge <= cyc;
      done_busy <= bus.busy_out;
    end
    if (bus.len_err) n_lenerr <= n_lenerr + 1;
  end

  task automatic request(input logic [63:0] data, input logic [3:0] len);
    @(negedge clk_in);
    bus.frame_data_in = data;
    bus.frame_len_in  = len;
    bus.send_req      = 1'b1;
    @(negedge clk_in);
    bus.send_req      = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (bus.tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({bus.uart_data_out, bus.uart_start_out, bus.busy_out, bus.tx_done, bus.len_err, bus.crc_out} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h start=%b busy=%b done=%b lerr=%b crc=%h, want all 0",
               bus.uart_data_out, bus.uart_start_out, bus.busy_out, bus.tx_done, bus.len_err, bus.crc_out);
    end
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_basic_frame();
    int bs = n_strobe;
    int bd = n_txdone;
    bit ok;
    request(F1, 4'd6);
    checks++;
    if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", bus.busy_out); end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: tx_done got 0 want 1"); end
    checks++;
    if (bus.crc_out !== 16'h0A84) begin errors++; $display("FAIL basic_crc: got %h want 0a84", bus.crc_out); end
    repeat (3) @(negedge clk_in);
    checks++;
    if (n_strobe - bs != 8) begin errors++; $display("FAIL basic_strobes: got %0d want 8", n_strobe - bs); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[(bs + i) % 128] !== EXP1[i]) begin
        errors++; $display("FAIL basic_byte%0d: got %h want %h", i, cap[(bs + i) % 128], EXP1[i]);
      end
    end
    checks++;
    if (done_edge - fall_edge != int'(GAP) + 1) begin
      errors++; $display("FAIL basic_gap: got %0d want %0d", done_edge - fall_edge, int'(GAP) + 1);
    end
    checks++;
    if (n_txdone - bd != 1 || done_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got pulses=%0d busy=%b want 1 and 0", n_txdone - bd, done_busy);
    end
  endtask

  task automatic test_min_len();
    int bs = n_strobe;
    bit ok;
    request(F3, 4'd1);
    wait_done(ok);
    checks++;
    if (!ok || bus.crc_out !== 16'h807E) begin
      errors++; $display("FAIL minlen_crc: got ok=%b crc=%h want 807e", ok, bus.crc_out);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (n_strobe - bs != 3) begin errors++; $display("FAIL minlen_strobes: got %0d want 3", n_strobe - bs); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap[(bs + i) % 128] !== EXP3[i]) begin
        errors++; $display("FAIL minlen_byte%0d: got %h want %h", i, cap[(bs + i) % 128], EXP3[i]);
      end
    end
  endtask

  task automatic test_len_err();
    int bs = n_strobe;
    int bd = n_txdone;
    int be = n_lenerr;
    int bad = 0;
    request(F1, 4'd0);
    repeat (3) @(negedge clk_in);
    request(F1, 4'd9);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (bus.busy_out || bus.uart_start_out || bus.tx_done) bad++;
    end
    checks++;
    if (n_lenerr - be != 2) begin errors++; $display("FAIL lenerr_pulses: got %0d want 2", n_lenerr - be); end
    checks++;
    if (bad != 0 || n_strobe != bs || n_txdone != bd) begin
      errors++; $display("FAIL lenerr_quiet: got active=%0d strobes=%0d dones=%0d want 0", bad, n_strobe - bs, n_txdone - bd);
    end
  endtask

  task automatic test_busy_hold();
    int bs;
    int bad = 0;
    bit ok;
    hold_busy = 1'b1;
    repeat (2) @(negedge clk_in);
    bs = n_strobe;
    request(F1, 4'd6);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (bus.uart_data_out !== 8'h01 || bus.uart_start_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || n_strobe != bs) begin
      errors++; $display("FAIL hold_no_strobe: got bad=%0d strobes=%0d want 0", bad, n_strobe - bs);
    end
    hold_busy = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || bus.crc_out !== 16'h0A84) begin errors++; $display("FAIL hold_crc: got ok=%b crc=%h want 0a84", ok, bus.crc_out); end
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[(bs + i) % 128] !== EXP1[i]) begin
        errors++; $display("FAIL hold_byte%0d: got %h want %h", i, cap[(bs + i) % 128], EXP1[i]);
      end
    end
  endtask

  task automatic test_mid_req();
    int bs = n_strobe;
    int bl = n_lenerr;
    bit ok;
    request(F1, 4'd6);
    for (int i = 0; i < 2000 && n_strobe < bs + 2; i++) @(negedge clk_in);
    request(F2, 4'd3);
    request(F2, 4'd0);
    wait_done(ok);
    checks++;
    if (!ok || bus.crc_out !== 16'h0A84) begin errors++; $display("FAIL midreq_crc: got ok=%b crc=%h want 0a84", ok, bus.crc_out); end
    repeat (2) @(negedge clk_in);
    checks++;
    if (n_strobe - bs != 8 || n_lenerr != bl) begin
      errors++; $display("FAIL midreq_counts: got strobes=%0d lenerr=%0d want 8 and 0", n_strobe - bs, n_lenerr - bl);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[(bs + i) % 128] !== EXP1[i]) begin
        errors++; $display("FAIL midreq_byte%0d: got %h want %h", i, cap[(bs + i) % 128], EXP1[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bs = n_strobe;
    bit ok;
    request(F1, 4'd6);
    for (int i = 0; i < 2000 && n_strobe < bs + 3; i++) @(negedge clk_in);
    checks++;
    if (n_strobe < bs + 3) begin errors++; $display("FAIL rstmid_reach: got strobes=%0d want 3", n_strobe - bs); end
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if ({bus.uart_data_out, bus.uart_start_out, bus.busy_out, bus.tx_done, bus.len_err, bus.crc_out} !== 28'd0) begin
      errors++;
      $display("FAIL rstmid_async: got data=%h start=%b busy=%b done=%b lerr=%b crc=%h, want all 0",
               bus.uart_data_out, bus.uart_start_out, bus.busy_out, bus.tx_done, bus.len_err, bus.crc_out);
    end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    bs = n_strobe;
    repeat (30) @(negedge clk_in);
    checks++;
    if (n_strobe != bs) begin errors++; $display("FAIL rstmid_abort: got strobes=%0d want 0", n_strobe - bs); end
    request(F2, 4'd6);
    wait_done(ok);
    checks++;
    if (!ok || bus.crc_out !== 16'hCDC5) begin errors++; $display("FAIL rstmid_crc: got ok=%b crc=%h want cdc5", ok, bus.crc_out); end
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[(bs + i) % 128] !== EXP2[i]) begin
        errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, cap[(bs + i) % 128], EXP2[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bs;
    bit ok;
    request(F1, 4'd6);
    wait_done(ok);
    bs = n_strobe;
    request(F2, 4'd6);
    checks++;
    if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy_out); end
    wait_done(ok);
    checks++;
    if (!ok || bus.crc_out !== 16'hCDC5) begin errors++; $display("FAIL b2b_crc: got ok=%b crc=%h want cdc5", ok, bus.crc_out); end
    repeat (2) @(negedge clk_in);
    checks++;
    if (cap[(bs + 6) % 128] !== 8'hC5 || cap[(bs + 7) % 128] !== 8'hCD) begin
      errors++; $display("FAIL b2b_tail: got %h %h want c5 cd", cap[(bs + 6) % 128], cap[(bs + 7) % 128]);
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL data_stable: got %0d changes want 0", stab_err); end
  endtask

  initial begin
    bus.frame_data_in = '0;
    bus.frame_len_in  = 4'd0;
    bus.send_req      = 1'b0;
    test_reset();
    test_basic_frame();
    test_min_len();
    test_len_err();
    test_busy_hold();
    test_mid_req();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modbus_frame_tx.md
Name: modbus_frame_tx

Overview:
- Transmit-side framer for the Modbus RTU slave.
- Takes a response payload (address, function, data) from the slave logic and streams it byte-by-byte to the UART transmitter.
- Computes CRC-16/Modbus on the fly and appends it, low byte first.
- Holds off for an inter-frame silence gap before reporting completion.

Parameters:
MAX_BYTES, 8, maximum payload bytes per frame, excluding CRC; legal range 1..15.
GAP_CYCLES, 16'd1750, clk_in cycles of enforced silence after the last CRC byte completes (t3.5 at the system baud).

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous reset, active low
frame_data_in  input  8*MAX_BYTES  payload; byte k (k=0 sent first) at bits [8*MAX_BYTES-1-8k -: 8]
frame_len_in  input  4  payload byte count, 1..MAX_BYTES
send_req  input  1  one-cycle request to start a frame
uart_busy_in  input  1  UART transmitter busy
uart_data_out  output  8  byte presented to UART
uart_start_out  output  1  one-cycle UART start strobe
busy_out  output  1  frame in progress, including gap
tx_done  output  1  one-cycle pulse at end of frame plus gap
len_err  output  1  one-cycle pulse when a request is rejected
crc_out  output  16  final CRC of the last frame, valid from tx_done

Behaviour:
- Reset is rst_n_in, asynchronous, active-low; clock is clk_in. Reset forces state IDLE.
- All outputs reset to 0: uart_data_out, uart_start_out, busy_out, tx_done, len_err, crc_out.
- Reset mid-frame aborts immediately. No further strobes are issued. crc_out clears.
- States: IDLE, LOAD, SEND, CRC, WAIT, NEXT, GAP, DONE.
- IDLE:
  - send_req=1 with 1<=frame_len_in<=MAX_BYTES: latch data and len, crc_reg<=16'hFFFF, byte index<=0, go to LOAD. busy_out rises the next cycle.
  - send_req=1 with len 0 or len >MAX_BYTES: pulse len_err for one cycle, stay in IDLE.
  - send_req while busy_out=1 is ignored, with no len_err.
- LOAD:
  - Payload byte: uart_data_out<=current byte and crc_reg[7:0]<=crc_reg[7:0]^byte.
  - CRC bytes: index len sends crc_reg[7:0]; index len+1 sends crc_reg[15:8]. CRC is not updated for CRC bytes.
  - Go to SEND.
- SEND:
  - If uart_busy_in=0: assert uart_start_out for exactly one cycle, then go to CRC for payload bytes or WAIT for CRC bytes.
  - Otherwise hold in SEND with no strobe.
  - uart_data_out stays stable from LOAD until the byte's WAIT exits.
- CRC: 8 cycles, one bit per cycle. If crc_reg[0]=1, crc_reg<=(crc_reg>>1)^16'hA001; else crc_reg<=crc_reg>>1. Then go to WAIT.
- UART contract: uart_busy_in is high from the cycle after uart_start_out until the byte is done. The CRC state guarantees busy is sampled after it has risen.
- WAIT: hold until uart_busy_in=0, then go to NEXT.
- NEXT: index+1. If index < len+1, go to LOAD; otherwise load the gap counter with GAP_CYCLES and go to GAP.
- GAP:
  - Count down to 0 while holding busy_out=1.
  - uart_busy_in is ignored.
  - GAP_CYCLES=0 goes straight to DONE.
- DONE:
  - crc_out<=crc_reg; tx_done=1 for one cycle; busy_out=0 in the same cycle; return to IDLE.
  - A new send_req is accepted from the following cycle.
- Total strobes per frame = len+2, in order: payload bytes, CRC low, CRC high.
- Index and counter widths cover MAX_BYTES+1 without wrap.

Test Plan:
- MAX_BYTES=8. Top 48 bits of frame_data_in = 0x010300000001, len=6, and a UART model with 10-cycle busy. Required: 8 strobes carrying 01 03 00 00 00 01 84 0A; crc_out=16'h0A84 at tx_done; tx_done exactly GAP_CYCLES+1 cycles after the last busy fall.
- Payload 0x01030000000A, len=6. Required: trailing bytes C5 CD; crc_out=16'hCDC5.
- len=0, then len=9. Required: len_err pulses once for each; busy_out, uart_start_out and tx_done stay 0.
- Hold uart_busy_in=1 for 50 cycles at frame start. Required: no strobe until busy falls; data stable; frame otherwise identical to the first scenario.
- send_req pulsed mid-frame. Required: ignored; output identical to the first scenario.
- Assert rst_n_in after the 3rd strobe. Required: all outputs 0 asynchronously. After release, a new request yields a correct full frame starting with CRC init FFFF.
